// File: rtl/nes_joypad_responder.sv
// NES controller poller with a two-wire bus read-only responder.
// The poller periodically latches and shifts out the controller buttons into an
// active-low snapshot; the bus side returns that snapshot to a host read at ADDRESS.
//
// Bus handshake: the host owns SCL; this block only pulls SDA low (sda_out=0)
// or releases it (sda_out=1), and changes sda_out only while SCL is low, in the
// cycle after a synchronized SCL falling edge (or on START/STOP/reset).
module nes_joypad_responder #(
    parameter logic [6:0] ADDRESS     = 7'h52,
    parameter int         POLL_PERIOD = 20000,
    parameter int         NES_HALF    = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_out,
    output logic nes_latch,
    output logic nes_clk,
    input  logic nes_data
);

    localparam int PCW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_PERIOD - 1);
    localparam int HTW = (NES_HALF > 1) ? $clog2(NES_HALF) : 1;
    localparam logic [HTW-1:0] HALF_LAST = HTW'(NES_HALF - 1);

    typedef enum logic [2:0] {
        BUS_IDLE,
        BUS_ADDR,
        BUS_ADDR_ACK,
        BUS_DATA,
        BUS_DATA_ACK
    } bus_state_e;

    typedef enum logic [1:0] {
        POLL_IDLE,
        POLL_LATCH,
        POLL_CLK_LO,
        POLL_CLK_HI
    } poll_state_e;

    // synchronizers (stage 2 is the synced value, stage 3 the edge reference)
    logic scl_s1_q, scl_s2_q, scl_s3_q;
    logic sda_s1_q, sda_s2_q, sda_s3_q;

    // bus side
    bus_state_e bus_state_q, bus_state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] addr_sr_q, addr_sr_d;
    logic [7:0] tx_q, tx_d;
    logic       sda_out_q, sda_out_d;

    // poll side
    poll_state_e      poll_state_q, poll_state_d;
    logic [PCW-1:0]   poll_cnt_q, poll_cnt_d;
    logic [HTW-1:0]   ptimer_q, ptimer_d;
    logic [2:0]       pbit_q, pbit_d;
    logic [7:0]       sample_q, sample_d;
    logic [7:0]       snapshot_q, snapshot_d;
    logic             nes_latch_q, nes_latch_d;
    logic             nes_clk_q, nes_clk_d;

    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_rise  = scl_s2_q & ~scl_s3_q;
    assign scl_fall  = ~scl_s2_q & scl_s3_q;
    assign start_det = scl_s2_q & ~sda_s2_q & sda_s3_q;
    assign stop_det  = scl_s2_q & sda_s2_q & ~sda_s3_q;

    assign sda_out   = sda_out_q;
    assign nes_latch = nes_latch_q;
    assign nes_clk   = nes_clk_q;

    // Input synchronizer chains; idle-high bus lines reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            scl_s3_q <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_s3_q <= 1'b1;
        end else begin
            scl_s1_q <= scl_in;
            scl_s2_q <= scl_s1_q;
            scl_s3_q <= scl_s2_q;
            sda_s1_q <= sda_in;
            sda_s2_q <= sda_s1_q;
            sda_s3_q <= sda_s2_q;
        end
    end

    // Bus FSM state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_state_q <= BUS_IDLE;
            bit_cnt_q   <= 4'd0;
            addr_sr_q   <= 8'h00;
            tx_q        <= 8'hFF;
            sda_out_q   <= 1'b1;
        end else begin
            bus_state_q <= bus_state_d;
            bit_cnt_q   <= bit_cnt_d;
            addr_sr_q   <= addr_sr_d;
            tx_q        <= tx_d;
            sda_out_q   <= sda_out_d;
        end
    end

    // Bus FSM next state: address decode, ACK drive, byte shifting, host ACK/NACK.
    always_comb begin
        bus_state_d = bus_state_q;
        bit_cnt_d   = bit_cnt_q;
        addr_sr_d   = addr_sr_q;
        tx_d        = tx_q;
        sda_out_d   = sda_out_q;
        if (start_det) begin
            bus_state_d = BUS_ADDR;
            bit_cnt_d   = 4'd0;
            sda_out_d   = 1'b1;
        end else if (stop_det) begin
            bus_state_d = BUS_IDLE;
            sda_out_d   = 1'b1;
        end else begin
            case (bus_state_q)
                BUS_ADDR: begin
                    if (scl_rise) begin
                        addr_sr_d = {addr_sr_q[6:0], sda_s2_q};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (addr_sr_d[7:1] == ADDRESS && addr_sr_d[0]) begin
                                bus_state_d = BUS_ADDR_ACK;
                                tx_d        = snapshot_q;
                                bit_cnt_d   = 4'd0;
                            end else begin
                                bus_state_d = BUS_IDLE;
                            end
                        end
                    end
                end
                BUS_ADDR_ACK: begin
                    // first falling edge starts the ACK slot, second one ends it
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd0) begin
                            sda_out_d = 1'b0;
                            bit_cnt_d = 4'd1;
                        end else begin
                            bus_state_d = BUS_DATA;
                            sda_out_d   = tx_q[7];
                            tx_d        = {tx_q[6:0], 1'b1};
                            bit_cnt_d   = 4'd1;
                        end
                    end
                end
                BUS_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            bus_state_d = BUS_DATA_ACK;
                            sda_out_d   = 1'b1;
                            bit_cnt_d   = 4'd0;
                        end else begin
                            sda_out_d = tx_q[7];
                            tx_d      = {tx_q[6:0], 1'b1};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                BUS_DATA_ACK: begin
                    // bit_cnt marks that the host ACKed and another byte follows
                    if (scl_rise) begin
                        if (!sda_s2_q) begin
                            tx_d      = snapshot_q;
                            bit_cnt_d = 4'd1;
                        end else begin
                            bus_state_d = BUS_IDLE;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        bus_state_d = BUS_DATA;
                        sda_out_d   = tx_q[7];
                        tx_d        = {tx_q[6:0], 1'b1};
                        bit_cnt_d   = 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Poller state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_state_q <= POLL_IDLE;
            poll_cnt_q   <= '0;
            ptimer_q     <= '0;
            pbit_q       <= 3'd0;
            sample_q     <= 8'hFF;
            snapshot_q   <= 8'hFF;
            nes_latch_q  <= 1'b0;
            nes_clk_q    <= 1'b1;
        end else begin
            poll_state_q <= poll_state_d;
            poll_cnt_q   <= poll_cnt_d;
            ptimer_q     <= ptimer_d;
            pbit_q       <= pbit_d;
            sample_q     <= sample_d;
            snapshot_q   <= snapshot_d;
            nes_latch_q  <= nes_latch_d;
            nes_clk_q    <= nes_clk_d;
        end
    end

    // Poller next state: period counter, latch pulse, 7 clock pulses, atomic snapshot.
    always_comb begin
        poll_state_d = poll_state_q;
        poll_cnt_d   = (poll_cnt_q == POLL_LAST) ? '0 : poll_cnt_q + PCW'(1);
        ptimer_d     = ptimer_q;
        pbit_d       = pbit_q;
        sample_d     = sample_q;
        snapshot_d   = snapshot_q;
        nes_latch_d  = nes_latch_q;
        nes_clk_d    = nes_clk_q;
        if (poll_cnt_q == POLL_LAST) begin
            poll_state_d = POLL_LATCH;
            ptimer_d     = '0;
            pbit_d       = 3'd0;
            nes_latch_d  = 1'b1;
            nes_clk_d    = 1'b1;
        end else begin
            case (poll_state_q)
                POLL_LATCH: begin
                    if (ptimer_q == HALF_LAST) begin
                        nes_latch_d  = 1'b0;
                        nes_clk_d    = 1'b0;
                        sample_d     = {sample_q[6:0], nes_data};
                        ptimer_d     = '0;
                        poll_state_d = POLL_CLK_LO;
                    end else begin
                        ptimer_d = ptimer_q + HTW'(1);
                    end
                end
                POLL_CLK_LO: begin
                    if (ptimer_q == HALF_LAST) begin
                        nes_clk_d    = 1'b1;
                        ptimer_d     = '0;
                        poll_state_d = POLL_CLK_HI;
                    end else begin
                        ptimer_d = ptimer_q + HTW'(1);
                    end
                end
                POLL_CLK_HI: begin
                    if (ptimer_q == HALF_LAST) begin
                        sample_d = {sample_q[6:0], nes_data};
                        ptimer_d = '0;
                        if (pbit_q == 3'd6) begin
                            snapshot_d   = {sample_q[6:0], nes_data};
                            poll_state_d = POLL_IDLE;
                        end else begin
                            pbit_d       = pbit_q + 3'd1;
                            nes_clk_d    = 1'b0;
                            poll_state_d = POLL_CLK_LO;
                        end
                    end else begin
                        ptimer_d = ptimer_q + HTW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nes_joypad_responder.sv
// Bench for nes_joypad_responder: behavioural NES controller, bit-banged bus host,
// expected-byte queue fed from the button state of the last completed poll.
module tb_nes_joypad_responder;

  localparam int P = 2000;  // poll period
  localparam int H = 3;     // NES half period
  localparam int T = 10;    // host bus half period in clk cycles

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl_in, sda_in, sda_out, nes_latch, nes_clk, nes_data;
  logic host_scl = 1'b1;
  logic host_sda = 1'b1;
  logic [7:0] buttons = 8'hFF;
  logic [7:0] ctrl_sr = 8'hFF;
  logic ctrl_clk_prev = 1'b1;
  logic watch = 1'b0;
  int low_seen = 0;
  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  assign scl_in = host_scl;
  assign sda_in = host_sda & sda_out;
  assign nes_data = ctrl_sr[7];

  nes_joypad_responder #(
    .ADDRESS(7'h52),
    .POLL_PERIOD(P),
    .NES_HALF(H)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .scl_in(scl_in),
    .sda_in(sda_in),
    .sda_out(sda_out),
    .nes_latch(nes_latch),
    .nes_clk(nes_clk),
    .nes_data(nes_data)
  );

  // clock
  always #5 clk = ~clk;

  // controller: parallel load while latched, shift on each rising shift clock
  always @(posedge clk) begin
    ctrl_clk_prev <= nes_clk;
    if (nes_latch) ctrl_sr <= buttons;
    else if (nes_clk && !ctrl_clk_prev) ctrl_sr <= {ctrl_sr[6:0], 1'b1};
  end

  // counts cycles where the responder pulls SDA low while watched
  always @(negedge clk) if (watch && sda_out === 1'b0) low_seen <= low_seen + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic hwait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    hwait(2);
    host_sda = 1'b1;
    hwait(T);
    host_scl = 1'b1;
    hwait(T);
    host_sda = 1'b0;
    hwait(T);
    host_scl = 1'b0;
  endtask

  task automatic bus_stop();
    hwait(2);
    host_sda = 1'b0;
    hwait(T);
    host_scl = 1'b1;
    hwait(T);
    host_sda = 1'b1;
    hwait(T);
  endtask

  task automatic write_bit(input logic b);
    hwait(2);
    host_sda = b;
    hwait(T);
    host_scl = 1'b1;
    hwait(T);
    host_scl = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    hwait(2);
    host_sda = 1'b1;
    hwait(T);
    host_scl = 1'b1;
    hwait(T / 2);
    b = sda_in;
    hwait(T - T / 2);
    host_scl = 1'b0;
  endtask

  task automatic send_addr(input logic [6:0] a, input logic rw, output logic ack);
    logic b;
    for (int i = 6; i >= 0; i--) write_bit(a[i]);
    write_bit(rw);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
  endtask

  // address + n bytes from the expected queue, NACK on the last, then STOP
  task automatic read_body(input int n);
    logic ack;
    logic [7:0] d;
    send_addr(7'h52, 1'b1, ack);
    check("addr_ack", ack, 1);
    for (int i = 0; i < n; i++) begin
      read_byte(d);
      check("rd_byte", d, exp_q.pop_front());
      write_bit(i < n - 1 ? 1'b0 : 1'b1);
    end
    hwait(5);
    check("sda_rel_nack", sda_out, 1);
    bus_stop();
  endtask

  task automatic read_txn(input int n);
    bus_start();
    read_body(n);
  endtask

  // wait for a complete fresh poll so the snapshot equals the current buttons
  task automatic wait_poll();
    int n;
    n = 0;
    while (nes_latch && n < 3 * P) begin
      @(negedge clk);
      n++;
    end
    while (!nes_latch && n < 3 * P) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3 * P) check("poll_timeout", 0, 1);
    hwait(15 * H + 10);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    int n;
    int w;
    int base;
    logic ack;
    logic b;
    logic [7:0] d;
    logic [7:0] b1;
    logic [7:0] b2;

    // reset state
    hwait(3);
    check("rst_sda_out", sda_out, 1);
    check("rst_nes_clk", nes_clk, 1);
    check("rst_nes_latch", nes_latch, 0);
    rst_n = 1'b1;

    // first latch pulse at cycle POLL_PERIOD, NES_HALF cycles wide
    n = 0;
    while (n < 2 * P) begin
      @(posedge clk);
      #1;
      n++;
      if (nes_latch) break;
      if (sda_out !== 1'b1) check("idle_sda", sda_out, 1);
    end
    check("first_latch_cycle", n, P);
    check("latch_nes_clk_high", nes_clk, 1);
    w = 0;
    do begin
      @(posedge clk);
      #1;
      w++;
    end while (nes_latch && w < 100);
    check("latch_width", w, H);

    // A and Right pressed
    buttons = 8'h7E;
    wait_poll();
    exp_q.push_back(8'h7E);
    read_txn(1);

    // wrong address / write direction: no ACK, SDA never pulled
    base = low_seen;
    watch = 1'b1;
    bus_start();
    send_addr(7'h53, 1'b1, ack);
    check("nack_addr53", ack, 0);
    bus_stop();
    bus_start();
    send_addr(7'h52, 1'b0, ack);
    check("nack_write", ack, 0);
    bus_stop();
    hwait(5);
    watch = 1'b0;
    check("no_low_drive", low_seen - base, 0);
    exp_q.push_back(8'h7E);
    read_txn(1);

    // two-byte read with buttons changed between the bytes
    b1 = 8'($urandom);
    b2 = b1 ^ 8'($urandom_range(1, 255));
    buttons = b1;
    wait_poll();
    bus_start();
    send_addr(7'h52, 1'b1, ack);
    check("addr_ack2", ack, 1);
    read_byte(d);
    check("two_byte_first", d, b1);
    buttons = b2;
    wait_poll();
    write_bit(1'b0);
    read_byte(d);
    check("two_byte_second", d, b2);
    write_bit(1'b1);
    hwait(5);
    check("sda_rel_nack2", sda_out, 1);
    bus_stop();

    // random button patterns and read lengths
    for (int k = 0; k < 4; k++) begin
      int nb;
      buttons = 8'($urandom);
      nb = $urandom_range(1, 3);
      wait_poll();
      for (int j = 0; j < nb; j++) exp_q.push_back(buttons);
      read_txn(nb);
    end

    // repeated START in the middle of a data byte
    buttons = 8'($urandom) | 8'h40;
    wait_poll();
    bus_start();
    send_addr(7'h52, 1'b1, ack);
    check("addr_ack3", ack, 1);
    read_bit(b);
    check("rs_first_bit", b, buttons[7]);
    bus_start();
    hwait(5);
    check("rs_sda_released", sda_out, 1);
    exp_q.push_back(buttons);
    read_body(1);

    // reset while the responder holds SDA low during data
    buttons = 8'($urandom) & 8'h7F;
    wait_poll();
    bus_start();
    send_addr(7'h52, 1'b1, ack);
    check("addr_ack4", ack, 1);
    hwait(6);
    check("data_bit_low", sda_out, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async_sda", sda_out, 1);
    check("rst_async_latch", nes_latch, 0);
    check("rst_async_nesclk", nes_clk, 1);
    hwait(3);
    rst_n = 1'b1;
    host_scl = 1'b1;
    host_sda = 1'b1;
    hwait(5);
    // no poll has completed yet, so the reset snapshot is returned
    exp_q.push_back(8'hFF);
    read_txn(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nes_joypad_responder.md
NES_JOYPAD_RESPONDER -- requirements
Module: nes_joypad_responder

Interface
REQ-001 Parameter ADDRESS, default 7'h52: 7-bit two-wire bus address this block answers.
REQ-002 Parameter POLL_PERIOD, default 20000: clk cycles between successive controller polls.
REQ-003 Parameter NES_HALF, default 6: clk cycles per half-period of nes_latch/nes_clk pulses.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 scl_in  input  1  bus clock from host (nes_bridge scl_out).
REQ-007 sda_in  input  1  bus data as seen on the wire.
REQ-008 sda_out  output  1  bus data drive; 0 = pull low, 1 = release.
REQ-009 nes_latch  output  1  controller latch strobe, active-high.
REQ-010 nes_clk  output  1  controller shift clock, idle high.
REQ-011 nes_data  input  1  controller serial data, active-low buttons.

Function
REQ-012 scl_in and sda_in SHALL pass through 2-flop synchronizers; all bus decoding uses synchronized values, with edges detected against a third registered copy.
REQ-013 START = synced SDA falling while synced SCL high; STOP = synced SDA rising while synced SCL high.
REQ-014 Bus FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK.
REQ-015 START from any state SHALL enter ADDR, clear the bit counter, and release sda_out; STOP from any state SHALL enter IDLE and release sda_out.
REQ-016 ADDR: sample SDA on each SCL rising edge, MSB first, 8 bits (7 address + R/W).
REQ-017 After the 8th bit: address == ADDRESS and R/W == 1 -> ADDR_ACK, load tx shift register from snapshot; otherwise -> IDLE (no ACK, sda_out stays 1).
REQ-018 ADDR_ACK: on the SCL falling edge ending bit 8, drive sda_out=0; hold through the ACK clock; on the next SCL falling edge enter DATA and drive tx bit 7.
REQ-019 DATA: on each SCL falling edge present the next tx bit (MSB first); after the 8th bit's SCL falling edge release sda_out and enter DATA_ACK.
REQ-020 DATA_ACK: sample SDA on SCL rising edge; 0 (ACK) -> reload tx from snapshot, return to DATA at next SCL falling edge; 1 (NACK) -> IDLE.
REQ-021 sda_out SHALL change only in the cycle after a detected synced SCL falling edge, or on START/STOP/reset.
REQ-022 Poller counter counts 0..POLL_PERIOD-1 and wraps; at wrap a poll sequence starts.
REQ-023 Poll: nes_latch high NES_HALF cycles, then low; sample nes_data into bit 7 (A); then 7 pulses of nes_clk (low NES_HALF, high NES_HALF), sampling nes_data NES_HALF cycles after each rising edge into bits 6..0 (B, Select, Start, Up, Down, Left, Right).
REQ-024 Snapshot (8-bit, active-low, 0 = pressed) SHALL update atomically in one cycle at the end of a poll, never with a partial value.
REQ-025 Snapshot update coinciding with a tx load: tx SHALL take the old snapshot; the new value appears on the next load.
REQ-026 Bus transfer and polling run concurrently and independently; a poll SHALL never stall or corrupt a transfer.

Reset
REQ-027 On rst_n low (asynchronous): FSM=IDLE, sda_out=1, nes_latch=0, nes_clk=1, snapshot=8'hFF, tx=8'hFF, poll counter=0, synchronizers=1.
REQ-028 Reset mid-transfer or mid-poll SHALL abandon it; after release, the first poll starts after POLL_PERIOD cycles and the bus waits for a fresh START.

Verification
REQ-029 Reset then no bus activity -> sda_out=1, nes_clk=1, nes_latch=0; first nes_latch pulse at cycle POLL_PERIOD, lasting NES_HALF cycles.
REQ-030 Controller model with A and Right pressed, one poll, then host read at 7'h52 -> ACK, byte 8'h7E on the wire, sda_out=1 after host NACK.
REQ-031 Host addresses 7'h53, or 7'h52 with R/W=0 -> no ACK, sda_out=1 throughout, FSM back in IDLE.
REQ-032 Host reads two bytes with ACK between, with button state changed in-between polls -> second byte reflects the newest completed snapshot.
REQ-033 Repeated START during DATA -> sda_out released immediately, new address phase decoded correctly.
REQ-034 rst_n asserted mid-DATA while sda_out=0 -> sda_out=1 in the same cycle, snapshot=8'hFF.
